i2c_master_xfer: RTL and testbench
==================================

Name: i2c_master_xfer

Overview:
Byte-level I2C initiator (controller) engine: the other end of the bridge's I2C target port. Accepts START / WRITE / READ / STOP commands from bridge control logic and drives SCL/SDA as open-drain pull-down enables. Samples the bus for ACK and read data. Supports target clock stretching. No multi-master arbitration.

Parameters:
CLK_DIV, 4, clk cycles per quarter-bit; legal range 2..255; SCL period = 4*CLK_DIV.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept a command
cmd  in  2  0=START, 1=WRITE, 2=READ, 3=STOP
wr_data  in  8  byte for WRITE, captured on accept
rd_nack  in  1  for READ: ACK bit to send (1=NACK); captured on accept
done  out  1  one-cycle pulse; command finished
rd_data  out  8  READ result; valid with done, held until next done
ack_nack  out  1  WRITE: sampled target ACK bit (1=NACK); held until next done
err  out  1  valid with done; command illegal in current bus state
busy  out  1  1 while the bus is owned (START issued, STOP not yet completed)
scl_i  in  1  SCL line level
sda_i  in  1  SDA line level
scl_oe  out  1  1 = pull SCL low
sda_oe  out  1  1 = pull SDA low

Behaviour:
- Reset: synchronous, active-high. Outputs: scl_oe=0, sda_oe=0, cmd_ready=1, done=0, err=0, busy=0, rd_data=0, ack_nack=0. FSM → IDLE and quarter counter cleared. Asserting rst mid-transfer releases both lines on the next clk edge. No STOP is generated.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready drops the cycle after accept and rises with done.
- Quarter tick: a counter counts 0..CLK_DIV-1 and pulses at wrap. Each command is a sequence of quarters q0..q3.
- Stretch rule: in any quarter where scl_oe=0 and a high SCL is expected, the counter holds while scl_i=0.
- States: IDLE, START, BIT, ACK, STOP, DONE.
- START (4 quarters):
  - q0: release SDA.
  - q1: release SCL (stretch).
  - q2: sda_oe=1.
  - q3: scl_oe=1.
  - Sets busy=1. START while busy=1 is a repeated start.
- WRITE (9 bits × 4 quarters, MSB first):
  - Bit i: q0 scl_oe=1 and sda_oe=~wr_data[7-i]; q1 hold; q2 release SCL (stretch); q3 hold SCL high.
  - 9th bit: SDA released; sda_i sampled into ack_nack at the q2→q3 boundary.
- READ: same timing as WRITE.
  - SDA released for bits 0..7; sda_i shifted in at q2→q3 (MSB first).
  - 9th bit: sda_oe=~rd_nack.
- STOP (4 quarters):
  - q0: scl_oe=1, sda_oe=1.
  - q1: release SCL (stretch).
  - q2: hold.
  - q3: release SDA.
  - Then busy=0.
- After a byte command the engine leaves scl_oe=1 (bus held low) and sda_oe=0.
- DONE: done=1 for exactly one cycle after the last quarter.
  - Latency with no stretching: START/STOP = 4*CLK_DIV+1 cycles; WRITE/READ = 36*CLK_DIV+1 cycles (accept cycle → done cycle).
- Errors: WRITE, READ or STOP while busy=0.
  - done=1 and err=1 on the cycle after accept.
  - No line activity; rd_data and ack_nack unchanged.
- No command is accepted in the same cycle as done. The next accept is possible on the cycle after done.

Decomposition:
- Package i2c_pkg: cmd encodings (I2C_CMD_START/WRITE/READ/STOP), FSM state enum, quarter-index constants. The bridge's I2C target also imports it.
- One sub-module, i2c_qtick: the quarter counter with stretch-hold input and tick output.
- Bit shifter and FSM stay in i2c_master_xfer.

Test Plan:
1. CLK_DIV=4, START then WRITE 0xA5; target model ACKs → sda_oe over bits 0..7 = 0,1,0,1,1,0,1,0; WRITE done 145 cycles after accept; ack_nack=0, err=0, busy=1.
2. READ with rd_nack=1; target drives 0x3C → rd_data=0x3C at done; sda_oe=0 during the 9th bit; then STOP → SDA rises while SCL high; busy=0.
3. Target holds scl_i low for 20 extra cycles in q2 of bit 3 of a WRITE → done arrives 20 cycles later than in scenario 1 (165 cycles); bit values unchanged.
4. WRITE while idle → done+err on the cycle after accept; scl_oe=sda_oe=0 throughout; cmd_ready back to 1 with done.
5. START, WRITE 0x84, START (repeated) → during q0–q1 of the repeated START, SDA is released before SCL; SDA falls while SCL high; busy stays 1.
6. Assert rst for one cycle during bit 5 of a WRITE → next cycle scl_oe=sda_oe=0, busy=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command encodings, engine state enum and quarter indices.
// Also imported by the bridge's I2C target.
package i2c_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'd0;
    localparam logic [1:0] I2C_CMD_WRITE = 2'd1;
    localparam logic [1:0] I2C_CMD_READ  = 2'd2;
    localparam logic [1:0] I2C_CMD_STOP  = 2'd3;

    localparam logic [1:0] I2C_Q0 = 2'd0;
    localparam logic [1:0] I2C_Q1 = 2'd1;
    localparam logic [1:0] I2C_Q2 = 2'd2;
    localparam logic [1:0] I2C_Q3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } i2c_state_e;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit timer: counts 0..CLK_DIV-1 while run is high and pulses tick on wrap.
// hold freezes the count so a target can stretch SCL.
module i2c_qtick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic tick
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == 8'(CLK_DIV - 1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_xfer.sv
// Byte-level I2C controller engine: executes START/WRITE/READ/STOP commands and
// drives SCL/SDA as registered open-drain pull-down enables.
module i2c_master_xfer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_nack,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       ack_nack,
    output logic       err,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    i2c_state_e state_q, state_d;
    logic [1:0] q_q, q_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic       is_rd_q, is_rd_d;
    logic       rd_nack_q, rd_nack_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ack_nack_q, ack_nack_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;

    logic run, hold, tick, accept, line_upd;

    assign run  = (state_q == ST_START) || (state_q == ST_BIT) ||
                  (state_q == ST_ACK)   || (state_q == ST_STOP);
    // A released SCL that still reads low is a target stretching the clock.
    assign hold = !scl_oe_q && !scl_i;

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .hold (hold),
        .tick (tick)
    );

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    // Ready is already high during done, but the new command is only taken once idle.
    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = done && err_q;
    assign busy      = busy_q;
    assign rd_data   = rd_data_q;
    assign ack_nack  = ack_nack_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        is_rd_d    = is_rd_q;
        rd_nack_d  = rd_nack_q;
        busy_d     = busy_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        ack_nack_d = ack_nack_q;
        scl_oe_d   = scl_oe_q;
        sda_oe_d   = sda_oe_q;
        line_upd   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    line_upd  = 1'b1;
                    err_d     = 1'b0;
                    q_d       = I2C_Q0;
                    bit_d     = '0;
                    is_rd_d   = (cmd == I2C_CMD_READ);
                    rd_nack_d = rd_nack;
                    case (cmd)
                        I2C_CMD_START: begin
                            state_d = ST_START;
                            busy_d  = 1'b1;
                        end
                        I2C_CMD_WRITE: begin
                            sh_d    = wr_data;
                            state_d = busy_q ? ST_BIT : ST_DONE;
                            err_d   = !busy_q;
                        end
                        I2C_CMD_READ: begin
                            sh_d    = '0;
                            state_d = busy_q ? ST_BIT : ST_DONE;
                            err_d   = !busy_q;
                        end
                        default: begin
                            state_d = busy_q ? ST_STOP : ST_DONE;
                            err_d   = !busy_q;
                        end
                    endcase
                end
            end
            ST_START, ST_STOP: begin
                if (tick) begin
                    line_upd = 1'b1;
                    if (q_q == I2C_Q3) begin
                        state_d = ST_DONE;
                        if (state_q == ST_STOP) begin
                            busy_d = 1'b0;
                        end
                    end else begin
                        q_d = q_q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    line_upd = 1'b1;
                    if (q_q == I2C_Q2 && is_rd_q) begin
                        sh_d = {sh_q[6:0], sda_i};
                    end
                    if (q_q == I2C_Q3) begin
                        q_d = I2C_Q0;
                        if (!is_rd_q) begin
                            sh_d = {sh_q[6:0], 1'b0};
                        end
                        if (bit_q == 3'd7) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        q_d = q_q + 2'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    line_upd = 1'b1;
                    // Write ACK is parked in sh[0]; ack_nack only changes with done.
                    if (q_q == I2C_Q2 && !is_rd_q) begin
                        sh_d = {sh_q[6:0], sda_i};
                    end
                    if (q_q == I2C_Q3) begin
                        state_d = ST_DONE;
                        if (is_rd_q) begin
                            rd_data_d = sh_q;
                        end else begin
                            ack_nack_d = sh_q[0];
                        end
                    end else begin
                        q_d = q_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line levels are set for the quarter being entered, so outputs stay glitch-free.
        if (line_upd) begin
            case (state_d)
                ST_START: begin
                    case (q_d)
                        I2C_Q0:  sda_oe_d = 1'b0;
                        I2C_Q1:  scl_oe_d = 1'b0;
                        I2C_Q2:  sda_oe_d = 1'b1;
                        default: scl_oe_d = 1'b1;
                    endcase
                end
                ST_BIT: begin
                    if (q_d == I2C_Q0) begin
                        scl_oe_d = 1'b1;
                        sda_oe_d = is_rd_d ? 1'b0 : ~sh_d[7];
                    end else if (q_d == I2C_Q2) begin
                        scl_oe_d = 1'b0;
                    end
                end
                ST_ACK: begin
                    if (q_d == I2C_Q0) begin
                        scl_oe_d = 1'b1;
                        sda_oe_d = is_rd_d ? ~rd_nack_d : 1'b0;
                    end else if (q_d == I2C_Q2) begin
                        scl_oe_d = 1'b0;
                    end
                end
                ST_STOP: begin
                    case (q_d)
                        I2C_Q0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end
                        I2C_Q1:  scl_oe_d = 1'b0;
                        I2C_Q3:  sda_oe_d = 1'b0;
                        default: ;
                    endcase
                end
                ST_DONE: begin
                    if (state_q == ST_ACK) begin
                        scl_oe_d = 1'b1;
                        sda_oe_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            q_q        <= I2C_Q0;
            bit_q      <= '0;
            sh_q       <= '0;
            is_rd_q    <= 1'b0;
            rd_nack_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            ack_nack_q <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            is_rd_q    <= is_rd_d;
            rd_nack_q  <= rd_nack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            ack_nack_q <= ack_nack_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_xfer.sv
// Directed bench for i2c_master_xfer with a small open-drain I2C target model.
module tb_i2c_master_xfer;
    import i2c_pkg::*;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_nack = 1'b0;
    logic       cmd_ready, done, ack_nack, err, busy;
    logic [7:0] rd_data;
    logic       scl_i, sda_i, scl_oe, sda_oe;

    logic       stretch = 1'b0;
    logic       tgt_low = 1'b0;
    int         tgt_mode = 0;
    int         tgt_cnt = 0;
    logic [7:0] tgt_byte = 8'h00;

    int   pass_cnt = 0;
    int   tot = 0;
    int   lat;
    logic e_at_done, rdy_at_done;
    logic sda_log [0:511];
    logic scl_log [0:511];

    assign scl_i = ~(scl_oe | stretch);
    assign sda_i = ~(sda_oe | tgt_low);

    always #5 clk = ~clk;

    i2c_master_xfer #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .rd_nack   (rd_nack),
        .done      (done),
        .rd_data   (rd_data),
        .ack_nack  (ack_nack),
        .err       (err),
        .busy      (busy),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    // Target: mode 1 ACKs a written byte, mode 2 returns tgt_byte; updates SDA on SCL fall.
    always @(negedge scl_i) begin
        if (tgt_mode != 0) begin
            tgt_cnt = tgt_cnt + 1;
            if (tgt_mode == 1) begin
                tgt_low = (tgt_cnt == 8);
            end else begin
                tgt_low = (tgt_cnt < 8) ? ~tgt_byte[7 - tgt_cnt] : 1'b0;
            end
        end
    end

    task automatic arm(input int mode, input logic [7:0] b);
        tgt_mode = mode;
        tgt_cnt  = 0;
        tgt_byte = b;
        tgt_low  = (mode == 2) ? ~b[7] : 1'b0;
    endtask

    task automatic disarm();
        tgt_mode = 0;
        tgt_low  = 1'b0;
    endtask

    // Called just after a negedge; logs line enables per cycle (index 0 = accept cycle).
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk);
        cmd       = c;
        wr_data   = d;
        rd_nack   = nk;
        cmd_valid = 1'b1;
        lat       = 0;
        sda_log[0] = sda_oe;
        scl_log[0] = scl_oe;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat = lat + 1;
            sda_log[lat] = sda_oe;
            scl_log[lat] = scl_oe;
        end while (!done && lat < 400);
        e_at_done   = err;
        rdy_at_done = cmd_ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tot++; if (scl_oe !== 1'b0) $display("FAIL rst_scl_oe got=%b exp=0", scl_oe); else pass_cnt++;
        tot++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); else pass_cnt++;
        tot++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); else pass_cnt++;
        tot++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else pass_cnt++;
        tot++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else pass_cnt++;
        tot++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
        tot++; if (rd_data !== 8'h00) $display("FAIL rst_rd_data got=%h exp=00", rd_data); else pass_cnt++;
        tot++; if (ack_nack !== 1'b0) $display("FAIL rst_ack_nack got=%b exp=0", ack_nack); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] exp_sda;
        exp_sda = 8'b0101_1010;
        issue(I2C_CMD_START, 8'h00, 1'b0);
        tot++; if (lat !== 17) $display("FAIL start_latency got=%0d exp=17", lat); else pass_cnt++;
        tot++; if (busy !== 1'b1) $display("FAIL start_busy got=%b exp=1", busy); else pass_cnt++;
        arm(1, 8'h00);
        issue(I2C_CMD_WRITE, 8'hA5, 1'b0);
        disarm();
        tot++; if (lat !== 145) $display("FAIL write_latency got=%0d exp=145", lat); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            tot++;
            if (sda_log[(4 * i + 1) * D + 2] !== exp_sda[7 - i])
                $display("FAIL write_bit%0d_sda_oe got=%b exp=%b", i, sda_log[(4 * i + 1) * D + 2], exp_sda[7 - i]);
            else pass_cnt++;
        end
        tot++; if (ack_nack !== 1'b0) $display("FAIL write_ack got=%b exp=0", ack_nack); else pass_cnt++;
        tot++; if (e_at_done !== 1'b0) $display("FAIL write_err got=%b exp=0", e_at_done); else pass_cnt++;
        tot++; if (busy !== 1'b1) $display("FAIL write_busy got=%b exp=1", busy); else pass_cnt++;
        tot++; if ({scl_oe, sda_oe} !== 2'b10) $display("FAIL write_end_lines got=%b%b exp=10", scl_oe, sda_oe); else pass_cnt++;
    endtask

    task automatic test_read_stop();
        arm(2, 8'h3C);
        issue(I2C_CMD_READ, 8'h00, 1'b1);
        disarm();
        tot++; if (lat !== 145) $display("FAIL read_latency got=%0d exp=145", lat); else pass_cnt++;
        tot++; if (rd_data !== 8'h3C) $display("FAIL read_data got=%h exp=3c", rd_data); else pass_cnt++;
        tot++; if (sda_log[6] !== 1'b0) $display("FAIL read_bit0_released got=%b exp=0", sda_log[6]); else pass_cnt++;
        tot++; if (sda_log[130] !== 1'b0 || sda_log[142] !== 1'b0)
            $display("FAIL read_nack_sda_oe got=%b%b exp=00", sda_log[130], sda_log[142]); else pass_cnt++;
        issue(I2C_CMD_STOP, 8'h00, 1'b0);
        tot++; if (lat !== 17) $display("FAIL stop_latency got=%0d exp=17", lat); else pass_cnt++;
        tot++; if ({scl_log[2], sda_log[2]} !== 2'b11) $display("FAIL stop_q0 got=%b%b exp=11", scl_log[2], sda_log[2]); else pass_cnt++;
        tot++; if ({scl_log[10], sda_log[10]} !== 2'b01) $display("FAIL stop_q2 got=%b%b exp=01", scl_log[10], sda_log[10]); else pass_cnt++;
        tot++; if ({scl_log[14], sda_log[14]} !== 2'b00) $display("FAIL stop_q3 got=%b%b exp=00", scl_log[14], sda_log[14]); else pass_cnt++;
        tot++; if (busy !== 1'b0) $display("FAIL stop_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_idle_err();
        logic [1:0] cl [3];
        cl[0] = I2C_CMD_WRITE;
        cl[1] = I2C_CMD_READ;
        cl[2] = I2C_CMD_STOP;
        for (int k = 0; k < 3; k++) begin
            issue(cl[k], 8'hFF, 1'b0);
            tot++; if (lat !== 1) $display("FAIL err%0d_latency got=%0d exp=1", k, lat); else pass_cnt++;
            tot++; if (e_at_done !== 1'b1) $display("FAIL err%0d_flag got=%b exp=1", k, e_at_done); else pass_cnt++;
            tot++; if (rdy_at_done !== 1'b1) $display("FAIL err%0d_ready got=%b exp=1", k, rdy_at_done); else pass_cnt++;
            tot++; if ({scl_log[0], sda_log[0], scl_log[1], sda_log[1], scl_oe, sda_oe} !== 6'b0)
                $display("FAIL err%0d_lines got=%b%b%b%b%b%b exp=000000", k, scl_log[0], sda_log[0], scl_log[1], sda_log[1], scl_oe, sda_oe);
            else pass_cnt++;
            tot++; if (rd_data !== 8'h3C || ack_nack !== 1'b0)
                $display("FAIL err%0d_held got=%h/%b exp=3c/0", k, rd_data, ack_nack); else pass_cnt++;
            tot++; if (busy !== 1'b0) $display("FAIL err%0d_busy got=%b exp=0", k, busy); else pass_cnt++;
        end
    endtask

    task automatic test_stretch();
        logic [7:0] exp_sda;
        int idx;
        exp_sda = 8'b0101_1010;
        issue(I2C_CMD_START, 8'h00, 1'b0);
        tot++; if (lat !== 17) $display("FAIL st_start_latency got=%0d exp=17", lat); else pass_cnt++;
        arm(1, 8'h00);
        fork
            issue(I2C_CMD_WRITE, 8'hA5, 1'b0);
            begin
                repeat (56) @(negedge clk);
                stretch = 1'b1;
                repeat (21) @(negedge clk);
                stretch = 1'b0;
            end
        join
        disarm();
        tot++; if (lat !== 165) $display("FAIL stretch_latency got=%0d exp=165", lat); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            idx = (4 * i + 1) * D + 2 + ((i >= 4) ? 20 : 0);
            tot++;
            if (sda_log[idx] !== exp_sda[7 - i])
                $display("FAIL stretch_bit%0d_sda_oe got=%b exp=%b", i, sda_log[idx], exp_sda[7 - i]);
            else pass_cnt++;
        end
        tot++; if (scl_log[70] !== 1'b0) $display("FAIL stretch_scl_released got=%b exp=0", scl_log[70]); else pass_cnt++;
        tot++; if (ack_nack !== 1'b0) $display("FAIL stretch_ack got=%b exp=0", ack_nack); else pass_cnt++;
    endtask

    task automatic test_repeated_start();
        issue(I2C_CMD_WRITE, 8'h84, 1'b0);
        tot++; if (lat !== 145) $display("FAIL rs_write_latency got=%0d exp=145", lat); else pass_cnt++;
        tot++; if (ack_nack !== 1'b1) $display("FAIL rs_write_nack got=%b exp=1", ack_nack); else pass_cnt++;
        issue(I2C_CMD_START, 8'h00, 1'b0);
        tot++; if (lat !== 17) $display("FAIL rs_latency got=%0d exp=17", lat); else pass_cnt++;
        tot++; if ({scl_log[0], sda_log[0]} !== 2'b10) $display("FAIL rs_before got=%b%b exp=10", scl_log[0], sda_log[0]); else pass_cnt++;
        tot++; if ({scl_log[2], sda_log[2]} !== 2'b10) $display("FAIL rs_q0 got=%b%b exp=10", scl_log[2], sda_log[2]); else pass_cnt++;
        tot++; if ({scl_log[6], sda_log[6]} !== 2'b00) $display("FAIL rs_q1 got=%b%b exp=00", scl_log[6], sda_log[6]); else pass_cnt++;
        tot++; if ({scl_log[10], sda_log[10]} !== 2'b01) $display("FAIL rs_q2 got=%b%b exp=01", scl_log[10], sda_log[10]); else pass_cnt++;
        tot++; if ({scl_log[16], sda_log[16]} !== 2'b11) $display("FAIL rs_q3 got=%b%b exp=11", scl_log[16], sda_log[16]); else pass_cnt++;
        tot++; if (busy !== 1'b1) $display("FAIL rs_busy got=%b exp=1", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        cmd       = I2C_CMD_WRITE;
        wr_data   = 8'h00;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (84) @(negedge clk);
        tot++; if ({scl_oe, sda_oe, busy} !== 3'b111)
            $display("FAIL mid_pre_rst got=%b%b%b exp=111", scl_oe, sda_oe, busy); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tot++; if ({scl_oe, sda_oe} !== 2'b00) $display("FAIL mid_rst_lines got=%b%b exp=00", scl_oe, sda_oe); else pass_cnt++;
        tot++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else pass_cnt++;
        tot++; if (cmd_ready !== 1'b1) $display("FAIL mid_rst_ready got=%b exp=1", cmd_ready); else pass_cnt++;
        seen = done;
        repeat (200) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tot++; if (seen !== 1'b0) $display("FAIL mid_rst_done got=%b exp=0", seen); else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read_stop();
        test_idle_err();
        test_stretch();
        test_repeated_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end

endmodule
